// File: rtl/spi_adc_sequencer.sv
// Periodic multi-channel ADC readout sequencer driving an SPI master.
// Optional macro SPI_ADC_PIPE_EN: pipelined ADC (extra dummy transaction, results lag one command).
module spi_adc_sequencer #(
  parameter int                    DATA_WIDTH    = 16,
  parameter int                    CH_NUM        = 4,
  parameter int                    SAMPLE_PERIOD = 2000,
  parameter logic [DATA_WIDTH-1:0] CMD_BASE      = 16'h8000,
  parameter int                    CH_SHIFT      = 10,
  parameter int                    TIMEOUT       = 1000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_err_clr,
  output logic                  o_spi_start,
  output logic [DATA_WIDTH-1:0] o_mosi_data,
  input  logic [DATA_WIDTH-1:0] i_miso_data,
  input  logic                  i_spi_valid,
  output logic [DATA_WIDTH-1:0] o_ch_data,
  output logic [3:0]            o_ch_id,
  output logic                  o_data_valid,
  output logic                  o_frame_done,
  output logic                  o_timeout,
  output logic                  o_overrun,
  output logic [2:0]            o_state
);

  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_START = 3'd2,
    S_XFER  = 3'd3,
    S_REL   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         per_q, per_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [4:0]            idx_q, idx_d;
  logic                  abort_q, abort_d;
  logic                  start_q, start_d;
  logic [DATA_WIDTH-1:0] mosi_q, mosi_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [3:0]            id_q, id_d;
  logic                  dv_q, dv_d;
  logic                  fd_q, fd_d;
  logic                  terr_q, terr_d;
  logic                  ovr_q, ovr_d;

  logic                  trig;
  logic                  tset;
  logic                  oset;
  logic [3:0]            cmd_ch;
  logic [3:0]            tag;
  logic                  cap_en;
  logic [DATA_WIDTH-1:0] cmd;

  // Pipelined ADC: result of transaction k belongs to command k-1
`ifdef SPI_ADC_PIPE_EN
  localparam int NTX = CH_NUM + 1;
  assign cmd_ch = (idx_q == 5'(CH_NUM)) ? 4'd0 : idx_q[3:0];
  assign tag    = 4'(idx_q - 5'd1);
  assign cap_en = (idx_q != 5'd0);
`else
  localparam int NTX = CH_NUM;
  assign cmd_ch = idx_q[3:0];
  assign tag    = idx_q[3:0];
  assign cap_en = 1'b1;
`endif

  assign cmd  = CMD_BASE | DATA_WIDTH'({28'd0, cmd_ch} << CH_SHIFT);
  assign trig = (state_q != S_IDLE) && (per_q == PW'(SAMPLE_PERIOD - 1));

  always_comb begin
    state_d = state_q;
    per_d   = per_q + 1'b1;
    tmo_d   = tmo_q;
    idx_d   = idx_q;
    abort_d = abort_q;
    mosi_d  = mosi_q;
    data_d  = data_q;
    id_d    = id_q;
    dv_d    = 1'b0;
    fd_d    = 1'b0;
    tset    = 1'b0;
    oset    = trig && (state_q != S_WAIT);
    if (state_q == S_IDLE || trig) per_d = '0;
    unique case (state_q)
      S_IDLE: begin
        if (i_en) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!i_en) begin
          state_d = S_IDLE;
        end else if (trig) begin
          state_d = S_START;
          idx_d   = '0;
          abort_d = 1'b0;
        end
      end
      S_START: begin
        mosi_d  = cmd;
        tmo_d   = '0;
        state_d = S_XFER;
      end
      S_XFER: begin
        if (i_spi_valid) begin
          data_d  = i_miso_data;
          id_d    = tag;
          dv_d    = cap_en;
          state_d = S_REL;
        end else if (tmo_q == TW'(TIMEOUT)) begin
          tset    = 1'b1;
          abort_d = 1'b1;
          state_d = S_REL;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_REL: begin
        if (!i_spi_valid) begin
          if (!i_en) begin
            state_d = S_IDLE;
          end else if (abort_q) begin
            state_d = S_WAIT;
          end else if (idx_q == 5'(NTX - 1)) begin
            fd_d    = 1'b1;
            state_d = S_WAIT;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = S_START;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    start_d = (state_d == S_XFER);
    terr_d  = tset | (terr_q & ~i_err_clr);
    ovr_d   = oset | (ovr_q & ~i_err_clr);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
      per_q   <= '0;
      tmo_q   <= '0;
      idx_q   <= '0;
      abort_q <= 1'b0;
      start_q <= 1'b0;
      mosi_q  <= '0;
      data_q  <= '0;
      id_q    <= '0;
      dv_q    <= 1'b0;
      fd_q    <= 1'b0;
      terr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      tmo_q   <= tmo_d;
      idx_q   <= idx_d;
      abort_q <= abort_d;
      start_q <= start_d;
      mosi_q  <= mosi_d;
      data_q  <= data_d;
      id_q    <= id_d;
      dv_q    <= dv_d;
      fd_q    <= fd_d;
      terr_q  <= terr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_spi_start  = start_q;
  assign o_mosi_data  = mosi_q;
  assign o_ch_data    = data_q;
  assign o_ch_id      = id_q;
  assign o_data_valid = dv_q;
  assign o_frame_done = fd_q;
  assign o_timeout    = terr_q;
  assign o_overrun    = ovr_q;
  assign o_state      = state_q;

endmodule
